// File: rtl/banked_memory.sv
// banked_memory: instruction/data word banks behind a single-request
// IDLE/WAIT/RESP handshake with a parameterised number of wait cycles.
module banked_memory #(
  parameter int WIDTH  = 13,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 13,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  dataIn,
  input  logic              write,
  input  logic              read,
  input  logic              instruction,
  output logic [WIDTH-1:0]  dataOut,
  output logic              Done,
  output logic              busy,
  output logic              err
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DEPTH_U   = DEPTH;
  localparam logic [3:0]  WAIT_LAST = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  din_q;
  logic              instr_q;
  logic              wr_q;
  logic [WIDTH-1:0]  dout_q;
  logic              done_q;
  logic              err_q;
  logic [WIDTH-1:0]  ibank_q [DEPTH];
  logic [WIDTH-1:0]  dbank_q [DEPTH];

  logic              req;
  logic              accept;
  logic              resp;
  logic              oor;
  logic [IDX_W-1:0]  idx;

  function automatic logic [WIDTH-1:0] boot_word(input int unsigned i);
    case (i)
      0:       boot_word = WIDTH'(13'b0000000010010);
      1:       boot_word = WIDTH'(13'b0010010100100);
      2:       boot_word = WIDTH'(13'b1000100010001);
      3:       boot_word = WIDTH'(13'b1010100100001);
      default: boot_word = '0;
    endcase
  endfunction

  assign req    = write | read;
  assign accept = (state_q == S_IDLE) && req;
  assign resp   = (state_q == S_RESP);
  // Range check uses the full latched address; only the low bits index.
  assign oor    = {1'b0, addr_q} >= DEPTH_EXT;
  assign idx    = addr_q[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = '0;
          state_d = (WAIT == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WAIT_LAST) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      din_q   <= '0;
      instr_q <= 1'b0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= address;
      din_q   <= dataIn;
      instr_q <= instruction;
      wr_q    <= write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_U; i++) begin
        ibank_q[IDX_W'(i)] <= boot_word(i);
        dbank_q[IDX_W'(i)] <= '0;
      end
    end else if (resp && wr_q && !oor) begin
      if (instr_q) ibank_q[idx] <= din_q;
      else         dbank_q[idx] <= din_q;
    end
  end

  // Done/err/dataOut are registered on the edge that leaves RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= resp;
      err_q  <= resp && oor;
      if (resp && !wr_q) begin
        if (oor)          dout_q <= '0;
        else if (instr_q) dout_q <= ibank_q[idx];
        else              dout_q <= dbank_q[idx];
      end
    end
  end

  assign dataOut = dout_q;
  assign Done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_banked_memory.sv
// Directed self-checking bench for banked_memory (default WAIT and WAIT=0).
module tb_banked_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] address;
  logic [12:0] dataIn;
  logic        write;
  logic        read;
  logic        instruction;
  logic [12:0] dataOut, dataOut0;
  logic        Done, Done0;
  logic        busy, busy0;
  logic        err, err0;

  int tests = 0;
  int fails = 0;

  int          lat, lat0, ndone, nerr;
  logic [12:0] r_dout, r_dout0;
  logic        r_err, busy1, busy_rst;

  localparam logic [12:0] BOOT0 = 13'b0000000010010;
  localparam logic [12:0] BOOT2 = 13'b1000100010001;
  localparam logic [12:0] BOOT3 = 13'b1010100100001;

  always #5 clk = ~clk;

  banked_memory u_dut (
    .clk(clk), .reset(reset), .address(address), .dataIn(dataIn),
    .write(write), .read(read), .instruction(instruction),
    .dataOut(dataOut), .Done(Done), .busy(busy), .err(err)
  );

  banked_memory #(.WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .address(address), .dataIn(dataIn),
    .write(write), .read(read), .instruction(instruction),
    .dataOut(dataOut0), .Done(Done0), .busy(busy0), .err(err0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request, then observe 10 negedges; n counts negedges after the accept edge.
  task automatic run_req(input logic w, input logic r, input logic ins,
                         input logic [12:0] a, input logic [12:0] d,
                         input bit inj, input bit rst_mid);
    @(negedge clk);
    write = w; read = r; instruction = ins; address = a; dataIn = d;
    lat = 0; lat0 = 0; ndone = 0; nerr = 0;
    r_dout = '0; r_dout0 = '0; r_err = 1'b0; busy1 = 1'b0; busy_rst = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin write = 1'b0; read = 1'b0; busy1 = busy; end
      if (inj && n == 2) begin
        write = 1'b1; address = 13'd6; dataIn = 13'h123; instruction = 1'b0;
      end
      if (inj && n == 3) write = 1'b0;
      if (rst_mid && n == 2) reset = 1'b1;
      if (rst_mid && n == 3) begin reset = 1'b0; busy_rst = busy; end
      if (err) nerr++;
      if (Done) begin
        ndone++;
        if (lat == 0) begin lat = n; r_dout = dataOut; r_err = err; end
      end
      if (Done0 && lat0 == 0) begin lat0 = n; r_dout0 = dataOut0; end
    end
  endtask

  task automatic rd(input logic ins, input logic [12:0] a);
    run_req(1'b0, 1'b1, ins, a, 13'd0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic ins, input logic [12:0] a, input logic [12:0] d);
    run_req(1'b1, 1'b0, ins, a, d, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; address = '0; dataIn = '0;
    write = 1'b0; read = 1'b0; instruction = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_done", Done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_dout", dataOut, 0);
    check_eq("rst_dout0", dataOut0, 0);
    reset = 1'b0;

    rd(1'b1, 13'd2);
    check_eq("i2_lat", lat, 4);
    check_eq("i2_dout", r_dout, BOOT2);
    check_eq("i2_err", r_err, 0);
    check_eq("i2_ndone", ndone, 1);
    check_eq("i2_busy", busy1, 1);
    check_eq("i2_lat0", lat0, 2);
    check_eq("i2_dout0", r_dout0, BOOT2);

    rd(1'b1, 13'd0);
    check_eq("i0_dout", r_dout, BOOT0);
    rd(1'b1, 13'd3);
    check_eq("i3_dout", r_dout, BOOT3);

    wr(1'b0, 13'd5, 13'h1ABC);
    check_eq("w5_lat", lat, 4);
    check_eq("w5_err", r_err, 0);
    check_eq("w5_dout_hold", r_dout, BOOT3);
    check_eq("w5_lat0", lat0, 2);
    rd(1'b1, 13'd5);
    check_eq("i5_dout", r_dout, 0);
    rd(1'b0, 13'd5);
    check_eq("d5_dout", r_dout, 13'h1ABC);

    run_req(1'b1, 1'b1, 1'b0, 13'd3, 13'd7, 1'b0, 1'b0);
    check_eq("rw3_lat", lat, 4);
    check_eq("rw3_dout_hold", r_dout, 13'h1ABC);
    rd(1'b0, 13'd3);
    check_eq("d3_dout", r_dout, 7);

    rd(1'b0, 13'd20);
    check_eq("oor_lat", lat, 4);
    check_eq("oor_err", r_err, 1);
    check_eq("oor_nerr", nerr, 1);
    check_eq("oor_dout", r_dout, 0);
    wr(1'b0, 13'd20, 13'h55);
    check_eq("oorw_err", r_err, 1);
    rd(1'b0, 13'd4);
    check_eq("d4_dout", r_dout, 0);
    check_eq("d4_err", r_err, 0);

    wr(1'b0, 13'd15, 13'h1FFF);
    check_eq("w15_err", r_err, 0);
    rd(1'b0, 13'd15);
    check_eq("d15_dout", r_dout, 13'h1FFF);
    rd(1'b0, 13'd16);
    check_eq("d16_err", r_err, 1);

    wr(1'b1, 13'd7, 13'h0F0);
    rd(1'b1, 13'd7);
    check_eq("i7_dout", r_dout, 13'h0F0);
    rd(1'b0, 13'd7);
    check_eq("d7_dout", r_dout, 0);

    run_req(1'b0, 1'b1, 1'b0, 13'd5, 13'd0, 1'b1, 1'b0);
    check_eq("ovl_ndone", ndone, 1);
    check_eq("ovl_dout", r_dout, 13'h1ABC);
    rd(1'b0, 13'd6);
    check_eq("ovl_d6", r_dout, 0);

    run_req(1'b1, 1'b0, 1'b0, 13'd1, 13'd9, 1'b0, 1'b1);
    check_eq("rm_ndone", ndone, 0);
    check_eq("rm_busy", busy_rst, 0);
    check_eq("rm_lat0", lat0, 2);
    rd(1'b0, 13'd1);
    check_eq("rm_d1", r_dout, 0);
    rd(1'b0, 13'd5);
    check_eq("rm_d5_clr", r_dout, 0);
    rd(1'b1, 13'd7);
    check_eq("rm_i7_boot", r_dout, 0);
    rd(1'b1, 13'd3);
    check_eq("rm_i3_boot", r_dout, BOOT3);

    @(negedge clk);
    reset = 1'b1; read = 1'b1; instruction = 1'b1; address = 13'd2;
    @(negedge clk);
    check_eq("rp_busy", busy, 0);
    reset = 1'b0; read = 1'b0;
    @(negedge clk);
    check_eq("rp_busy2", busy, 0);
    check_eq("rp_dout", dataOut, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/banked_memory.md
BANKED_MEMORY -- requirements
Module: banked_memory

Interface
REQ-001 Parameter WIDTH, default 13, SHALL set the word width of both banks and of the data ports.
REQ-002 Parameter DEPTH, default 16, SHALL set the number of words in each bank (instruction and data).
REQ-003 Parameter ADDR_W, default 13, SHALL set the address port width.
REQ-004 Parameter WAIT, default 2, range 0-15, SHALL set the wait cycles inserted between request accept and completion.
REQ-005 clk  in  1  system clock; all state changes on rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 address  in  ADDR_W  word address of the request.
REQ-008 dataIn  in  WIDTH  write data.
REQ-009 write  in  1  write request.
REQ-010 read  in  1  read request.
REQ-011 instruction  in  1  bank select: 1 = instruction bank, 0 = data bank.
REQ-012 dataOut  out  WIDTH  read data, registered.
REQ-013 Done  out  1  one-cycle completion pulse.
REQ-014 busy  out  1  high while a request is in flight.
REQ-015 err  out  1  one-cycle pulse with Done when the address was out of range.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT, and RESP.
REQ-017 In IDLE, if write or read is high on a rising edge, the block SHALL latch address, dataIn, instruction, and the operation, then go to WAIT; otherwise it SHALL stay in IDLE.
REQ-018 If write and read are both high, the request SHALL be treated as a write only.
REQ-019 WAIT SHALL count exactly WAIT cycles and then go to RESP; with WAIT=0, WAIT SHALL last zero cycles, so RESP follows accept directly.
REQ-020 In RESP, a write SHALL update the selected bank at the latched address, and a read SHALL load dataOut from the selected bank at the latched address.
REQ-021 RESP SHALL assert Done for exactly that cycle, then return to IDLE.
REQ-022 Total latency SHALL be WAIT+2 cycles from the accept edge to Done high, i.e. 4 cycles at the defaults.
REQ-023 busy SHALL be high in WAIT and RESP and low in IDLE.
REQ-024 Requests presented while busy SHALL be ignored, not queued.
REQ-025 A new request SHALL be acceptable on the first IDLE cycle after Done.
REQ-026 A write with instruction=1 SHALL write the instruction bank (program load).
REQ-027 A read SHALL never modify either bank.
REQ-028 An address >= DEPTH SHALL complete normally with err=1 at Done; no bank SHALL be written, and dataOut SHALL be set to 0 on a read.
REQ-029 Only the low clog2(DEPTH) address bits SHALL index the banks, after the range check.
REQ-030 dataOut SHALL hold its value between reads, and writes SHALL not alter it.
REQ-031 The block SHALL contain no combinational path from inputs to outputs.

Reset
REQ-032 On a reset edge, the FSM SHALL go to IDLE, and Done, busy, and err SHALL be 0.
REQ-033 On a reset edge, dataOut SHALL be 0 and every data-bank word SHALL be 0.
REQ-034 On a reset edge, instruction words 0-3 SHALL load 13'b0000000010010, 13'b0010010100100, 13'b1000100010001, and 13'b1010100100001, and all remaining instruction words SHALL load 0.
REQ-035 Reset asserted mid-request SHALL abort the request: no write commits, and no Done is produced.
REQ-036 Reset SHALL take priority over any simultaneous request.

Verification
REQ-037 Reset, then read instruction bank addr 2 -> Done high 4 cycles after accept, dataOut=13'b1000100010001, err=0.
REQ-038 Write data addr 5 value 13'h1ABC, wait for Done, then read data addr 5 -> dataOut=13'h1ABC; a read of instruction addr 5 -> 0.
REQ-039 Assert read and write together at data addr 3 with dataIn=7 -> treated as a write; dataOut unchanged; a later read of addr 3 -> 7.
REQ-040 Read addr 20 with DEPTH=16 -> Done and err high together, dataOut=0; a following read of data addr 4 -> unchanged 0.
REQ-041 Issue a second request while busy=1 -> ignored: exactly one Done; the second address's contents unaffected.
REQ-042 Write data addr 1 value 9, then assert reset during WAIT -> no Done; busy=0 next cycle; a later read of addr 1 -> 0; repeat with WAIT=0 -> Done at 2 cycles.
